// File: rtl/ifetch_pkg.sv
// +----------------------------------------------------------------------------+
// | ifetch_pkg                                                                 |
// | Shared constants and the IF/ID record type for the instruction fetch unit.|
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package ifetch_pkg;

   localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES        = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'd0;
   localparam logic [31:0] DEFAULT_MEM_BYTES = 32'd1024;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } ifid_t;

   localparam ifid_t IFID_NOP = '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};

endpackage

`default_nettype wire

// File: rtl/ifid_reg.sv
// +----------------------------------------------------------------------------+
// | ifid_reg                                                                   |
// | IF/ID pipeline record: load, hold, or clear to NOP; clear wins over load. |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifid_reg
   import ifetch_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  logic  clear,
   input  ifid_t d,
   output ifid_t q
);

   ifid_t rec_d;
   ifid_t rec_q;

   always_comb begin
      rec_d = rec_q;
      if (clear) begin
         rec_d = IFID_NOP;
      end else if (load) begin
         rec_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rec_q <= IFID_NOP;
      end else begin
         rec_q <= rec_d;
      end
   end

   assign q = rec_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | instruction_fetch_unit                                                     |
// | PC, halt and fetch counting feeding the IF/ID register. Optional macro:   |
// | IFETCH_BRANCH_SQUASH_EN discards the instruction fetched on a redirect.    |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module instruction_fetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] MEM_BYTES = DEFAULT_MEM_BYTES
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   output logic [31:0] Address,
   input  logic [31:0] Instruction,
   output logic [31:0] InstrOut,
   output logic [31:0] PCPlus4Out,
   output logic        ValidOut,
   output logic        Halted,
   output logic [31:0] FetchCount
);

   logic [31:0] pc_d, pc_q;
   logic        halted_d, halted_q;
   logic [31:0] fetch_count_d, fetch_count_q;

   logic        ifid_load;
   logic        ifid_clear;
   ifid_t       ifid_in;
   ifid_t       ifid_out;
   logic [31:0] pc_plus4;
   logic        pc_past_end;
   logic [1:0]  unused_target_bits;

   assign pc_plus4           = pc_q + WORD_BYTES;
   assign pc_past_end        = (pc_q >= MEM_BYTES);
   assign unused_target_bits = BranchTarget[1:0];

   always_comb begin
      pc_d          = pc_q;
      halted_d      = halted_q;
      fetch_count_d = fetch_count_q;
      ifid_load     = 1'b0;
      ifid_clear    = 1'b0;
      ifid_in       = '{instr: Instruction, pc_plus4: pc_plus4, valid: 1'b1};

      if (BranchTaken) begin
         pc_d     = {BranchTarget[31:2], 2'b00};
         halted_d = 1'b0;
`ifdef IFETCH_BRANCH_SQUASH_EN
         ifid_clear = 1'b1;
`else
         // Delay slot: the word fetched alongside the branch still retires.
         if (!Stall) begin
            ifid_load     = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
         end
`endif
      end else if (halted_q || pc_past_end) begin
         halted_d   = 1'b1;
         ifid_clear = 1'b1;
      end else if (!Stall) begin
         pc_d          = pc_plus4;
         ifid_load     = 1'b1;
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         pc_q          <= RESET_PC;
         halted_q      <= 1'b0;
         fetch_count_q <= 32'd0;
      end else begin
         pc_q          <= pc_d;
         halted_q      <= halted_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   ifid_reg u_ifid_reg (
      .clk   (Clk),
      .rst   (Rst),
      .load  (ifid_load),
      .clear (ifid_clear),
      .d     (ifid_in),
      .q     (ifid_out)
   );

   assign Address    = pc_q;
   assign InstrOut   = ifid_out.instr;
   assign PCPlus4Out = ifid_out.pc_plus4;
   assign ValidOut   = ifid_out.valid;
   assign Halted     = halted_q;
   assign FetchCount = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_instruction_fetch_unit                                                  |
// | Self-checking bench: vector table plus hand sequences for halt and reset. |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instruction_fetch_unit;

`ifdef IFETCH_BRANCH_SQUASH_EN
   localparam int SQ = 1;
`else
   localparam int SQ = 0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        halted;
      logic [31:0] count;
   } exp_t;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        br;
   logic [31:0] tgt;
   logic [31:0] addr;
   logic [31:0] instr_in;
   logic [31:0] instr_out;
   logic [31:0] pc4_out;
   logic        valid;
   logic        halted;
   logic [31:0] fcount;

   logic [31:0] mem [0:255];
   exp_t        sb[$];
   vec_t        vecs[12];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   assign instr_in = (addr < 32'd1024) ? mem[addr[9:2]] : 32'hDEAD_BEEF;

   instruction_fetch_unit dut (
      .Clk          (clk),
      .Rst          (rst),
      .Stall        (stall),
      .BranchTaken  (br),
      .BranchTarget (tgt),
      .Address      (addr),
      .Instruction  (instr_in),
      .InstrOut     (instr_out),
      .PCPlus4Out   (pc4_out),
      .ValidOut     (valid),
      .Halted       (halted),
      .FetchCount   (fcount)
   );

   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] i,
                               input logic [31:0] p, input logic v,
                               input logic h, input logic [31:0] c);
      exp_t e;
      e.addr = a; e.instr = i; e.pc4 = p; e.valid = v; e.halted = h; e.count = c;
      return e;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check(input exp_t e);
      cmp("Address",    addr,              e.addr);
      cmp("InstrOut",   instr_out,         e.instr);
      cmp("PCPlus4Out", pc4_out,           e.pc4);
      cmp("ValidOut",   {31'd0, valid},    {31'd0, e.valid});
      cmp("Halted",     {31'd0, halted},   {31'd0, e.halted});
      cmp("FetchCount", fcount,            e.count);
   endtask

   task automatic step(input logic r, input logic s, input logic b,
                       input logic [31:0] t, input exp_t e);
      exp_t x;
      sb.push_back(e);
      rst = r; stall = s; br = b; tgt = t;
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check(x);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[0] = 32'h2013_0001;
      mem[1] = 32'h2011_0006;

      // Main run: stall at 8, branch to 7 (-> 4) at PC 20, branch+stall at PC 8.
      vecs[0]  = '{1'b0, 1'b0, 32'd0, mk(32'd4,  mem[0], 32'd4,  1'b1, 1'b0, 32'd1)};
      vecs[1]  = '{1'b0, 1'b0, 32'd0, mk(32'd8,  mem[1], 32'd8,  1'b1, 1'b0, 32'd2)};
      vecs[2]  = '{1'b1, 1'b0, 32'd0, mk(32'd8,  mem[1], 32'd8,  1'b1, 1'b0, 32'd2)};
      vecs[3]  = '{1'b1, 1'b0, 32'd0, mk(32'd8,  mem[1], 32'd8,  1'b1, 1'b0, 32'd2)};
      vecs[4]  = '{1'b1, 1'b0, 32'd0, mk(32'd8,  mem[1], 32'd8,  1'b1, 1'b0, 32'd2)};
      vecs[5]  = '{1'b0, 1'b0, 32'd0, mk(32'd12, mem[2], 32'd12, 1'b1, 1'b0, 32'd3)};
      vecs[6]  = '{1'b0, 1'b0, 32'd0, mk(32'd16, mem[3], 32'd16, 1'b1, 1'b0, 32'd4)};
      vecs[7]  = '{1'b0, 1'b0, 32'd0, mk(32'd20, mem[4], 32'd20, 1'b1, 1'b0, 32'd5)};
      vecs[8]  = '{1'b0, 1'b1, 32'h0000_0007,
                   mk(32'd4, (SQ != 0) ? 32'd0 : mem[5], (SQ != 0) ? 32'd0 : 32'd24,
                      (SQ == 0), 1'b0, 32'(6 - SQ))};
      vecs[9]  = '{1'b0, 1'b0, 32'd0, mk(32'd8, mem[1], 32'd8, 1'b1, 1'b0, 32'(7 - SQ))};
      vecs[10] = '{1'b1, 1'b1, 32'h0000_0040,
                   mk(32'h40, (SQ != 0) ? 32'd0 : mem[1], (SQ != 0) ? 32'd0 : 32'd8,
                      (SQ == 0), 1'b0, 32'(7 - SQ))};
      vecs[11] = '{1'b0, 1'b0, 32'd0, mk(32'h44, mem[16], 32'h44, 1'b1, 1'b0, 32'(8 - SQ))};

      step(1'b1, 1'b0, 1'b0, 32'd0, mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
      step(1'b1, 1'b0, 1'b0, 32'd0, mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
      for (int i = 0; i < 12; i++) step(1'b0, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].e);

      // Linear run to the end of memory, then halt and redirect.
      step(1'b1, 1'b0, 1'b0, 32'd0, mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
      for (int i = 0; i < 256; i++)
         step(1'b0, 1'b0, 1'b0, 32'd0,
              mk(32'(4 * (i + 1)), mem[i], 32'(4 * (i + 1)), 1'b1, 1'b0, 32'(i + 1)));
      step(1'b0, 1'b0, 1'b0, 32'd0, mk(32'd1024, 32'd0, 32'd0, 1'b0, 1'b1, 32'd256));
      step(1'b0, 1'b1, 1'b0, 32'd0, mk(32'd1024, 32'd0, 32'd0, 1'b0, 1'b1, 32'd256));
      step(1'b0, 1'b0, 1'b1, 32'd0,
           mk(32'd0, (SQ != 0) ? 32'd0 : 32'hDEAD_BEEF, (SQ != 0) ? 32'd0 : 32'd1028,
              (SQ == 0), 1'b0, 32'(257 - SQ)));
      step(1'b0, 1'b0, 1'b0, 32'd0, mk(32'd4, mem[0], 32'd4, 1'b1, 1'b0, 32'(258 - SQ)));

      // Halt again under stall, then reset out of it.
      step(1'b0, 1'b0, 1'b1, 32'd1024,
           mk(32'd1024, (SQ != 0) ? 32'd0 : mem[1], (SQ != 0) ? 32'd0 : 32'd8,
              (SQ == 0), 1'b0, 32'(259 - 2 * SQ)));
      step(1'b0, 1'b1, 1'b0, 32'd0, mk(32'd1024, 32'd0, 32'd0, 1'b0, 1'b1, 32'(259 - 2 * SQ)));
      step(1'b1, 1'b1, 1'b0, 32'd0, mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0));
      step(1'b0, 1'b0, 1'b0, 32'd0, mk(32'd4, mem[0], 32'd4, 1'b1, 1'b0, 32'd1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-stage initiator for the 4-stage pipeline: owns the program counter, drives the word address into the instruction memory, captures the returned instruction into the IF/ID register, and handles stall, branch redirect and end-of-program halt. It sits between the instruction memory (combinational read on address change) and the decode stage.

## Interface
- RESET_PC, 32'd0, PC value loaded on reset
- MEM_BYTES, 1024, size of instruction memory in bytes; fetch halts at PC >= MEM_BYTES
- Clk  in  1  single clock, all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- Stall  in  1  hold PC and IF/ID contents
- BranchTaken  in  1  redirect request from a later stage
- BranchTarget  in  32  redirect address; bits [1:0] ignored (forced 00)
- Address  out  32  to instruction memory; always equals PC
- Instruction  in  32  memory read data, valid in the same cycle as Address
- InstrOut  out  32  IF/ID instruction
- PCPlus4Out  out  32  IF/ID PC+4 of InstrOut
- ValidOut  out  1  IF/ID holds a real instruction
- Halted  out  1  sticky: PC ran past MEM_BYTES
- FetchCount  out  32  number of valid instructions delivered since reset

## Operation
- Reset (Rst=1 at edge): PC=RESET_PC, InstrOut=32'h0000_0000 (NOP), PCPlus4Out=0, ValidOut=0, Halted=0, FetchCount=0.
- Priority per edge: Rst > BranchTaken > Halted > Stall > normal.
- Normal: PC<=PC+4; IF/ID<={Instruction, PC+4}; ValidOut<=1; FetchCount+=1.
- Stall (no branch): PC, IF/ID, ValidOut, FetchCount hold.
- BranchTaken (overrides Stall and Halted): PC<={BranchTarget[31:2],2'b00}; Halted<=0; IF/ID handling per Configuration.
- Halt: if PC >= MEM_BYTES at an edge with no branch, Halted<=1, PC holds, IF/ID<=NOP, ValidOut<=0. Remains until reset or redirect to any target.
- PC arithmetic modulo 2^32; FetchCount wraps modulo 2^32.
- Address[1:0] always 00.

## Timing
- Address changes only at Clk edges (registered PC); memory data sampled same cycle.
- Fetch-to-IF/ID latency: 1 cycle. First ValidOut=1 on the first edge after Rst deasserts.
- Redirect latency: target appears on Address the cycle after BranchTaken is sampled.
- Stall is level; one held cycle per asserted edge, no lost or duplicated instruction.
- Rst mid-stall or mid-halt: reset values on next edge regardless.

## Configuration
- IFETCH_BRANCH_SQUASH_EN defined: on BranchTaken the instruction fetched that cycle is discarded: IF/ID<=NOP, ValidOut<=0, FetchCount unchanged.
- Undefined (default): delay-slot semantics; the instruction fetched in the BranchTaken cycle is loaded into IF/ID with ValidOut=1 and counted (unless Stall also asserted, in which case IF/ID holds). Programs place filler after branches.

## Structure
- Package ifetch_pkg: NOP_INSTR (32'h0), WORD_BYTES (4), default RESET_PC and MEM_BYTES, IF/ID record typedef {instr, pc_plus4, valid}.
- One sub-module: ifid_reg (load/hold/clear register for the IF/ID record); PC and halt logic stay in the top.

## Test plan
- Reset then run with memory word0=32'h20130001, word1=32'h20110006 -> cycle 1 InstrOut=32'h20130001, PCPlus4Out=4, ValidOut=1; cycle 2 InstrOut=32'h20110006, PCPlus4Out=8.
- Stall held 3 cycles at PC=8 -> Address stays 8, IF/ID and FetchCount unchanged, then resumes with word at 8, no duplicate.
- BranchTaken with target 32'h0000_0007 at PC=20 -> next Address=4; delay-slot build: IF/ID gets word at 20, ValidOut=1; squash build: InstrOut=0, ValidOut=0.
- BranchTaken and Stall same cycle -> PC redirected; IF/ID holds (default build).
- Run linear to PC=1024 -> Halted=1, ValidOut=0, Address stays 1024; then BranchTaken target 0 -> Halted=0, fetch resumes at 0.
- Rst asserted while Halted and stalled -> all outputs return to reset values next edge, FetchCount=0.
